// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with binary wrap-bit pointers and registered read data
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_Full,
  output logic                  fifo_Empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  // flags and acceptance from the pre-edge pointers; the wrap bit separates full from empty
  always_comb begin
    fifo_Empty = wr_ptr == rd_ptr;
    fifo_Full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    wr_ok = wr_en && !fifo_Full;
    rd_ok = rd_en && !fifo_Empty;
  end
  // pointers and read register; reset empties the FIFO and wins over any request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end
  // storage is never cleared, only written on accepted writes
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: randomized and directed checks of async_fifo against a queue model
module tb_async_fifo;
  logic clk = 0;
  logic rst_n = 0;
  logic wr_en = 0;
  logic rd_en = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data;
  logic fifo_Full, fifo_Empty;
  int errors = 0;
  int checks = 0;
  logic [7:0] q [$];
  logic [7:0] exp_rd = 0;
  logic [7:0] next_word = 0;

  async_fifo #(8, 4) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .fifo_Full(fifo_Full), .fifo_Empty(fifo_Empty)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic rn);
    logic aw, ar;
    wr_en = w; wr_data = d; rd_en = r; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      exp_rd = 0;
    end else begin
      aw = w && q.size() < 16;
      ar = r && q.size() != 0;
      if (ar) exp_rd = q.pop_front();
      if (aw) q.push_back(d);
    end
    #1;
    wr_en = 0; rd_en = 0; rst_n = 1;
  endtask

  task automatic test_reset;
    cycle(1, 8'h33, 1, 0);
    cycle(1, 8'h44, 1, 0);
    checks++; if (fifo_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", fifo_Empty); end
    checks++; if (fifo_Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", fifo_Full); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 8'(i), 0, 1);
      checks++; if (fifo_Full !== (i == 16)) begin errors++; $display("FAIL fill_full i=%0d got=%b want=%b", i, fifo_Full, i == 16); end
      checks++; if (fifo_Empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got=%b want=0", i, fifo_Empty); end
    end
    cycle(1, 8'hAA, 0, 1);
    checks++; if (fifo_Full !== 1'b1 || q.size() != 16) begin errors++; $display("FAIL fill_drop full=%b occ=%0d want full=1 occ=16", fifo_Full, q.size()); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 8'h00, 1, 1);
      checks++; if (rd_data !== 8'(i > 16 ? 16 : i)) begin errors++; $display("FAIL drain_data i=%0d got=%h want=%h", i, rd_data, 8'(i > 16 ? 16 : i)); end
      checks++; if (fifo_Empty !== (i >= 16) || fifo_Full !== 1'b0) begin errors++; $display("FAIL drain_flags i=%0d empty=%b full=%b want empty=%b full=0", i, fifo_Empty, fifo_Full, i >= 16); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] expect_word;
    expect_word = 8'h40;
    next_word = 8'h40;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        cycle(1, next_word, 0, 1);
        next_word++;
        checks++; if (fifo_Full !== 1'b0 || fifo_Empty !== 1'b0) begin errors++; $display("FAIL wrap_wflags r=%0d i=%0d full=%b empty=%b want 0 0", r, i, fifo_Full, fifo_Empty); end
      end
      for (int i = 0; i < 10; i++) begin
        cycle(0, 8'h00, 1, 1);
        checks++; if (rd_data !== expect_word) begin errors++; $display("FAIL wrap_data r=%0d i=%0d got=%h want=%h", r, i, rd_data, expect_word); end
        expect_word++;
      end
      checks++; if (fifo_Empty !== 1'b1) begin errors++; $display("FAIL wrap_empty r=%0d got=%b want=1", r, fifo_Empty); end
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] held;
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom), 1, 1);
      checks++; if (rd_data !== exp_rd || q.size() != 5) begin errors++; $display("FAIL simul_mid i=%0d got=%h want=%h occ=%0d", i, rd_data, exp_rd, q.size()); end
      checks++; if (fifo_Empty !== 1'b0 || fifo_Full !== 1'b0) begin errors++; $display("FAIL simul_mid_flags i=%0d empty=%b full=%b want 0 0", i, fifo_Empty, fifo_Full); end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 1, 1);
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL simul_drain i=%0d got=%h want=%h", i, rd_data, exp_rd); end
    end
    held = rd_data;
    cycle(1, 8'h77, 1, 1);
    checks++; if (rd_data !== held || fifo_Empty !== 1'b0) begin errors++; $display("FAIL simul_empty rd=%h want=%h empty=%b want=0", rd_data, held, fifo_Empty); end
    cycle(0, 8'h00, 1, 1);
    checks++; if (rd_data !== 8'h77 || fifo_Empty !== 1'b1) begin errors++; $display("FAIL simul_empty_read got=%h want=77 empty=%b", rd_data, fifo_Empty); end
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h90 + i), 0, 1);
    cycle(1, 8'hEE, 1, 1);
    checks++; if (rd_data !== 8'h90 || fifo_Full !== 1'b0) begin errors++; $display("FAIL simul_full got=%h want=90 full=%b want=0", rd_data, fifo_Full); end
    for (int i = 1; i < 16; i++) begin
      cycle(0, 8'h00, 1, 1);
      checks++; if (rd_data !== 8'(8'h90 + i)) begin errors++; $display("FAIL simul_full_drain i=%0d got=%h want=%h", i, rd_data, 8'(8'h90 + i)); end
    end
    checks++; if (fifo_Empty !== 1'b1) begin errors++; $display("FAIL simul_full_empty got=%b want=1", fifo_Empty); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h20 + i), 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(1, 8'h99, 1, 0);
    checks++; if (fifo_Empty !== 1'b1 || fifo_Full !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL rstmid empty=%b full=%b rd=%h want 1 0 00", fifo_Empty, fifo_Full, rd_data); end
    cycle(1, 8'h5C, 0, 1);
    cycle(0, 8'h00, 1, 1);
    checks++; if (rd_data !== 8'h5C || fifo_Empty !== 1'b1) begin errors++; $display("FAIL rstmid_read got=%h want=5c empty=%b", rd_data, fifo_Empty); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 199) != 0));
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL random_data i=%0d got=%h want=%h", i, rd_data, exp_rd); end
      checks++; if (fifo_Empty !== (q.size() == 0) || fifo_Full !== (q.size() == 16)) begin errors++; $display("FAIL random_flags i=%0d empty=%b full=%b occ=%0d", i, fifo_Empty, fifo_Full, q.size()); end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/async_fifo.md
# async_fifo

Single-clock synchronous FIFO that buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain. It keeps the established asy_fifo port set and flag names, and replaces the dual-clock variant where both sides run on one clock. Storage is a 2**ADDR_WIDTH-entry register array with binary read/write pointers. Full/empty status derives from the pointers.

## Interface
- DATA_WIDTH, default 8: word width in bits. Set positionally as the first parameter.
- ADDR_WIDTH, default 4: log2 of depth, giving DEPTH = 16 entries.
- clk, in, 1: the single clock. All state updates on the rising edge.
- rst_n, in, 1: reset. One clock; reset is synchronous and active-low.
- wr_en, in, 1: write request.
- wr_data, in, DATA_WIDTH: word to write.
- rd_en, in, 1: read request.
- rd_data, out, DATA_WIDTH: registered read data.
- fifo_Full, out, 1: FIFO holds DEPTH words.
- fifo_Empty, out, 1: FIFO holds 0 words.

## Operation
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits (the extra MSB is a wrap bit).
  - mem[0:DEPTH-1].
  - rd_data register.
- Flags, combinational from the pointers:
  - fifo_Empty = (wr_ptr == rd_ptr).
  - fifo_Full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]).
- Write accepted when wr_en && !fifo_Full, using flags as they stand before the edge.
  - mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data.
  - wr_ptr increments by 1.
- Read accepted when rd_en && !fifo_Empty, using flags before the edge.
  - rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]].
  - rd_ptr increments by 1.
- Rejected requests have no effect on any state:
  - write while full: data dropped, no error flag;
  - read while empty: rd_data holds its value.
- Pointers wrap modulo 2**(ADDR_WIDTH+1), with natural binary overflow. Storage addresses wrap modulo DEPTH.
- Simultaneous write and read are evaluated independently against the pre-edge flags:
  - neither full nor empty: both accepted, occupancy unchanged.
  - empty: only the write is accepted. A word is never read in the cycle it is written.
  - full: only the read is accepted. The write is dropped, and the producer must retry.
- rd_data holds its last value whenever no read is accepted.
- Order is strictly first-in first-out. No data is duplicated or lost except rejected writes.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - wr_ptr = 0, rd_ptr = 0, rd_data = 0.
  - Hence fifo_Empty = 1 and fifo_Full = 0 from that edge on.
  - Memory contents are not cleared.
  - Reset overrides any wr_en/rd_en in the same cycle.
- Reset asserted mid-operation discards all stored words. After it, the FIFO behaves as freshly reset.
- Write-to-flag latency:
  - fifo_Empty deasserts right after the edge that accepts the first write.
  - fifo_Full asserts right after the edge that accepts the DEPTH-th unread word.
- Read latency: rd_data presents the word one edge after the rd_en edge that accepts it.
- Minimum write-to-read latency: a word written at edge N can be accepted by a read at edge N+1 and is visible on rd_data after edge N+1.
- Throughput: one write and one read per cycle, sustained.
- Inputs are sampled only at the rising edge of clk. There is no combinational path from inputs to outputs except via the flags.

## Test plan
- Reset: rst_n = 0 for 2 edges with wr_en = rd_en = 1 -> fifo_Empty = 1, fifo_Full = 0, rd_data = 8'h00, pointers 0.
- Fill: write 8'h01..8'h10 (16 words), then an extra 8'hAA -> fifo_Full = 1 after the 16th write edge. 8'hAA is dropped and occupancy stays 16.
- Drain: rd_en = 1 for 17 cycles after the fill -> rd_data = 8'h01..8'h10 in order, one word per edge. fifo_Empty = 1 after the 16th read. The 17th read leaves rd_data = 8'h10.
- Wrap-around: 3 rounds of write 10 / read 10 with incrementing data (30 words) -> all words return in order across the pointer wrap. Flags stay correct: full never asserts, empty asserts after each round.
- Simultaneous: with 5 words stored, wr_en = rd_en = 1 for 20 cycles -> occupancy stays 5 and output order is preserved. Repeat at empty (write only accepted) and at full (read only accepted, write dropped).
- Reset mid-operation: with 7 words stored, pulse rst_n = 0 for one edge -> fifo_Empty = 1 and rd_data = 0. A following write of 8'h5C then read returns 8'h5C.
